intarb: RTL and testbench

INTARB -- requirements
Module: intarb

---
 rtl/intarb.sv | 170 +++++++++++++++++
 tb/tb_intarb.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/intarb.sv
// Interrupt arbiter: grants one BR level, runs the SACK/INTR vector handshake
// and holds the captured vector until the CPU acknowledges it.
module intarb #(
    parameter int TIMEOUT = 255,
    parameter int DESKEW  = 2
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        init_in_h,
    input  logic [3:0]  br_in_h,
    input  logic [2:0]  cpu_pri,
    input  logic        cpu_ready,
    input  logic        sack_in_h,
    input  logic        bbsy_in_h,
    input  logic        intr_in_h,
    input  logic [15:0] d_in_h,
    input  logic        vec_ack,
    output logic [3:0]  bg_out_h,
    output logic        ssyn_out_h,
    output logic        vec_valid,
    output logic [7:0]  vec_out,
    output logic [2:0]  vec_level,
    output logic        to_err
);

    typedef enum logic [2:0] {
        IDLE, GRANT, SACKED, XFER, WAITREL, HOLD
    } state_t;

    localparam logic [7:0] TMAX = 8'(TIMEOUT);
    localparam logic [7:0] DMAX = 8'(DESKEW - 1);

    state_t     state;
    logic [7:0] timer;
    logic [7:0] dcnt;
    logic [7:0] timer_nx;
    logic       pick_ok;
    logic [2:0] pick_lvl;
    logic       held;
    logic       unused_d;

    // Only the vector bits of the data bus are captured.
    assign unused_d = ^{d_in_h[15:8], d_in_h[1:0]};

    // Saturating increment; the timer never wraps past TIMEOUT.
    assign timer_nx = (timer == TMAX) ? TMAX : timer + 8'd1;

    // Request line of the level currently being granted (level 4..7 -> bit 0..3).
    assign held = br_in_h[vec_level[1:0]];

    // Highest pending BR level strictly above the CPU priority.
    always_comb begin
        pick_ok  = 1'b0;
        pick_lvl = 3'd0;
        if (br_in_h[3] && cpu_pri < 3'd7) begin
            pick_ok  = 1'b1;
            pick_lvl = 3'd7;
        end else if (br_in_h[2] && cpu_pri < 3'd6) begin
            pick_ok  = 1'b1;
            pick_lvl = 3'd6;
        end else if (br_in_h[1] && cpu_pri < 3'd5) begin
            pick_ok  = 1'b1;
            pick_lvl = 3'd5;
        end else if (br_in_h[0] && cpu_pri < 3'd4) begin
            pick_ok  = 1'b1;
            pick_lvl = 3'd4;
        end
    end

    // Arbitration FSM with registered bus outputs, timers and vector capture.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state      <= IDLE;
            timer      <= 8'd0;
            dcnt       <= 8'd0;
            bg_out_h   <= 4'd0;
            ssyn_out_h <= 1'b0;
            vec_valid  <= 1'b0;
            vec_out    <= 8'd0;
            vec_level  <= 3'd0;
            to_err     <= 1'b0;
        end else if (init_in_h) begin
            state      <= IDLE;
            timer      <= 8'd0;
            dcnt       <= 8'd0;
            bg_out_h   <= 4'd0;
            ssyn_out_h <= 1'b0;
            vec_valid  <= 1'b0;
            vec_out    <= 8'd0;
            vec_level  <= 3'd0;
            to_err     <= 1'b0;
        end else begin
            to_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_ready && !sack_in_h && !bbsy_in_h && pick_ok) begin
                        state     <= GRANT;
                        bg_out_h  <= 4'b0001 << pick_lvl[1:0];
                        vec_level <= pick_lvl;
                        timer     <= 8'd0;
                    end
                end
                GRANT: begin
                    if (sack_in_h) begin
                        state    <= SACKED;
                        bg_out_h <= 4'd0;
                        timer    <= 8'd0;
                    end else if (!held) begin
                        state    <= IDLE;
                        bg_out_h <= 4'd0;
                        timer    <= 8'd0;
                    end else if (timer_nx == TMAX) begin
                        state    <= IDLE;
                        bg_out_h <= 4'd0;
                        timer    <= 8'd0;
                        to_err   <= 1'b1;
                    end else begin
                        timer <= timer_nx;
                    end
                end
                SACKED: begin
                    if (intr_in_h && bbsy_in_h) begin
                        state <= XFER;
                        dcnt  <= 8'd0;
                        timer <= 8'd0;
                    end else if (!sack_in_h && !intr_in_h) begin
                        state <= IDLE;
                        timer <= 8'd0;
                    end else if (timer_nx == TMAX) begin
                        state  <= IDLE;
                        timer  <= 8'd0;
                        to_err <= 1'b1;
                    end else begin
                        timer <= timer_nx;
                    end
                end
                XFER: begin
                    if (!intr_in_h) begin
                        state <= SACKED;
                        timer <= 8'd0;
                    end else if (dcnt == DMAX) begin
                        state      <= WAITREL;
                        vec_out    <= {d_in_h[7:2], 2'b00};
                        ssyn_out_h <= 1'b1;
                        timer      <= 8'd0;
                    end else begin
                        dcnt <= dcnt + 8'd1;
                    end
                end
                WAITREL: begin
                    if (!intr_in_h) begin
                        state      <= HOLD;
                        ssyn_out_h <= 1'b0;
                        vec_valid  <= 1'b1;
                        timer      <= 8'd0;
                    end
                end
                HOLD: begin
                    if (vec_ack) begin
                        state     <= IDLE;
                        vec_valid <= 1'b0;
                        timer     <= 8'd0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_intarb.sv
// Directed bench for intarb: grant selection, vector handshake,
// timeout, SACK withdrawal, INIT and async reset.
module tb_intarb;

    logic        CLOCK;
    logic        RESET;
    logic        init_in_h;
    logic [3:0]  br_in_h;
    logic [2:0]  cpu_pri;
    logic        cpu_ready;
    logic        sack_in_h;
    logic        bbsy_in_h;
    logic        intr_in_h;
    logic [15:0] d_in_h;
    logic        vec_ack;
    logic [3:0]  bg_out_h;
    logic        ssyn_out_h;
    logic        vec_valid;
    logic [7:0]  vec_out;
    logic [2:0]  vec_level;
    logic        to_err;

    int checks   = 0;
    int failures = 0;

    intarb #(.TIMEOUT(255), .DESKEW(2)) dut (
        .CLOCK      (CLOCK),
        .RESET      (RESET),
        .init_in_h  (init_in_h),
        .br_in_h    (br_in_h),
        .cpu_pri    (cpu_pri),
        .cpu_ready  (cpu_ready),
        .sack_in_h  (sack_in_h),
        .bbsy_in_h  (bbsy_in_h),
        .intr_in_h  (intr_in_h),
        .d_in_h     (d_in_h),
        .vec_ack    (vec_ack),
        .bg_out_h   (bg_out_h),
        .ssyn_out_h (ssyn_out_h),
        .vec_valid  (vec_valid),
        .vec_out    (vec_out),
        .vec_level  (vec_level),
        .to_err     (to_err)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Inputs change on negedges; outputs are sampled on the following negedge.
    task automatic tick(input int n);
        repeat (n) @(negedge CLOCK);
    endtask

    // From GRANT: SACK, then INTR with data; checks BG drop and deskew timing.
    task automatic run_to_ssyn(input string tag, input logic [15:0] data);
        sack_in_h = 1'b1;
        tick(1);
        check({tag, "_bg_sack"}, bg_out_h, 4'b0000);
        br_in_h   = 4'b0000;
        intr_in_h = 1'b1;
        bbsy_in_h = 1'b1;
        d_in_h    = data;
        tick(1);
        check({tag, "_ssyn_e1"}, ssyn_out_h, 1'b0);
        tick(1);
        check({tag, "_ssyn_e2"}, ssyn_out_h, 1'b0);
        tick(1);
        check({tag, "_ssyn_e3"}, ssyn_out_h, 1'b1);
        check({tag, "_bg_ssyn"}, bg_out_h, 4'b0000);
    endtask

    initial begin
        int hi;
        int errs;
        RESET     = 1'b0;
        init_in_h = 1'b0;
        br_in_h   = 4'b0000;
        cpu_pri   = 3'd0;
        cpu_ready = 1'b0;
        sack_in_h = 1'b0;
        bbsy_in_h = 1'b0;
        intr_in_h = 1'b0;
        d_in_h    = 16'd0;
        vec_ack   = 1'b0;
        #1;
        check("reset_outs",
              {bg_out_h, ssyn_out_h, vec_valid, vec_out, vec_level, to_err},
              20'd0);
        tick(2);
        RESET = 1'b1;
        tick(1);

        // BR5 over cpu_pri 3, full vector transfer of 0o060
        cpu_pri   = 3'd3;
        cpu_ready = 1'b1;
        br_in_h   = 4'b0010;
        tick(1);
        check("t1_bg", bg_out_h, 4'b0010);
        check("t1_lvl", vec_level, 3'd5);
        run_to_ssyn("t1", 16'o060);
        check("t1_vec", vec_out, 8'h30);
        intr_in_h = 1'b0;
        bbsy_in_h = 1'b0;
        sack_in_h = 1'b0;
        tick(1);
        check("t1_ssyn_rel", ssyn_out_h, 1'b0);
        check("t1_valid", vec_valid, 1'b1);
        check("t1_lvl_hold", vec_level, 3'd5);
        vec_ack = 1'b1;
        tick(1);
        check("t1_valid_ack", vec_valid, 1'b0);
        vec_ack = 1'b0;

        // BR4+BR6 -> BG6; late BR7 does not disturb the grant
        cpu_pri = 3'd0;
        br_in_h = 4'b0101;
        tick(1);
        check("t2_bg", bg_out_h, 4'b0100);
        check("t2_lvl", vec_level, 3'd6);
        br_in_h = 4'b1101;
        tick(1);
        check("t2_bg_br7a", bg_out_h, 4'b0100);
        tick(1);
        check("t2_bg_br7b", bg_out_h, 4'b0100);
        br_in_h = 4'b0000;
        tick(1);
        check("t2_bg_drop", bg_out_h, 4'b0000);

        // cpu_pri masks BR6 until it drops to 5
        cpu_pri = 3'd6;
        br_in_h = 4'b0100;
        tick(3);
        check("t3_masked", bg_out_h, 4'b0000);
        cpu_pri = 3'd5;
        tick(1);
        check("t3_bg", bg_out_h, 4'b0100);
        br_in_h = 4'b0000;
        tick(1);
        check("t3_bg_drop", bg_out_h, 4'b0000);

        // No SACK: grant abandoned after TIMEOUT cycles with one to_err pulse
        cpu_pri = 3'd3;
        br_in_h = 4'b0010;
        hi      = 0;
        errs    = 0;
        for (int i = 0; i < 270; i++) begin
            tick(1);
            if (to_err) errs++;
            if (bg_out_h != 4'b0000) hi++;
            else if (hi > 0) br_in_h = 4'b0000;
        end
        check("t4_grant_cycles", hi, 255);
        check("t4_err_pulses", errs, 1);
        check("t4_bg_idle", bg_out_h, 4'b0000);

        // SACK withdrawn without INTR -> IDLE, no error
        br_in_h = 4'b0010;
        tick(1);
        check("t5_bg", bg_out_h, 4'b0010);
        sack_in_h = 1'b1;
        tick(1);
        check("t5_bg_sack", bg_out_h, 4'b0000);
        br_in_h   = 4'b0000;
        sack_in_h = 1'b0;
        tick(1);
        check("t5_err", {to_err, ssyn_out_h}, 2'b00);
        tick(1);
        check("t5_err2", {to_err, ssyn_out_h}, 2'b00);
        br_in_h = 4'b0001;
        tick(1);
        check("t5_idle_regrant", bg_out_h, 4'b0001);
        br_in_h = 4'b0000;
        tick(1);
        check("t5_bg_drop", bg_out_h, 4'b0000);

        // INIT during WAITREL clears the transfer
        br_in_h = 4'b0100;
        tick(1);
        check("t6_bg", bg_out_h, 4'b0100);
        run_to_ssyn("t6", 16'hFFAD);
        check("t6_vec", vec_out, 8'hAC);
        init_in_h = 1'b1;
        tick(1);
        check("t6_init",
              {ssyn_out_h, vec_valid, vec_out, vec_level, bg_out_h},
              17'd0);
        init_in_h = 1'b0;
        intr_in_h = 1'b0;
        bbsy_in_h = 1'b0;
        sack_in_h = 1'b0;
        tick(1);

        // INIT mid-GRANT
        br_in_h = 4'b0010;
        tick(1);
        check("t7_bg", bg_out_h, 4'b0010);
        init_in_h = 1'b1;
        tick(1);
        check("t7_init_bg", bg_out_h, 4'b0000);
        init_in_h = 1'b0;
        br_in_h   = 4'b0000;
        tick(1);

        // Async RESET mid-GRANT clears BG before the next clock edge
        br_in_h = 4'b1000;
        tick(1);
        check("t8_bg", bg_out_h, 4'b1000);
        #1;
        RESET = 1'b0;
        #1;
        check("t8_async_bg", bg_out_h, 4'b0000);
        check("t8_async_lvl", vec_level, 3'd0);
        tick(1);
        RESET   = 1'b1;
        br_in_h = 4'b0000;
        tick(1);
        check("t8_after", bg_out_h, 4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
